// File: rtl/multi_source_interrupt_controller_pkg.sv
// Shared types and injected opcodes for the multi-source interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IMM,
    WAIT_JMP,
    BUBBLE,
    PUSH1,
    PUSH2,
    REDIRECT
  } ctrlState_e;

  localparam logic [15:0] BUBBLE_INSTR = 16'h07F8;
  localparam logic [15:0] INT_OP1      = 16'hF480;
  localparam logic [15:0] INT_OP2      = 16'hF4C0;

  // Source-id width; a single source still needs one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_source_interrupt_controller_irq_pending_prio.sv
// Edge capture into a sticky pending register, masking, and lowest-index selection.
module irq_pending_prio #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic [NUM_SRC-1:0] clr_onehot,
  output logic [NUM_SRC-1:0] pending,
  output logic               any_eligible,
  output logic [ID_W-1:0]    sel_id
);

  logic [NUM_SRC-1:0] irqQ;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;

  assign rise = irq & ~irqQ;

  // A fresh edge beats a same-cycle clear so the new request is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqQ    <= '0;
      pending <= '0;
    end else begin
      irqQ    <= irq;
      pending <= (pending & ~clr_onehot) | rise;
    end
  end

  assign eligible     = pending & ~irq_mask;
  assign any_eligible = |eligible;

  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/multi_source_interrupt_controller.sv
// Multi-source interrupt controller: injects bubble / PC-push pair / IVT redirect at fetch.
module multi_source_interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int PC_WIDTH      = 32,
  parameter int INSTR_WIDTH   = 16,
  parameter int BUBBLE_CYCLES = 1,
  parameter int JMP_WAIT      = 1,
  parameter int IVT_BASE      = 0,
  parameter int IVT_STRIDE    = 2,
  localparam int ID_W         = idWidth(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     irq,
  input  logic [NUM_SRC-1:0]     irq_mask,
  input  logic                   global_en,
  input  logic                   fetch_has_imm,
  input  logic                   decode_is_jmp,
  input  logic [PC_WIDTH-1:0]    next_pc,
  output logic                   inject_active,
  output logic [INSTR_WIDTH-1:0] inject_instr,
  output logic                   save_pc_valid,
  output logic [PC_WIDTH-1:0]    save_pc,
  output logic                   redirect_valid,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id,
  output logic [NUM_SRC-1:0]     pending
);

  localparam logic [2:0] BUB_LAST = 3'(BUBBLE_CYCLES - 1);
  localparam logic [2:0] JMP_LAST = 3'(JMP_WAIT - 1);

  ctrlState_e          state, stateNxt;
  logic [2:0]          cnt, cntNxt;
  logic [PC_WIDTH-1:0] savedPc, savedPcNxt;
  logic [ID_W-1:0]     activeId, activeIdNxt, selId;
  logic                anyEligible, accept;
  logic [NUM_SRC-1:0]  clrOnehot;
  logic [PC_WIDTH-1:0] ivtTarget;

  irq_pending_prio #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) uPrio (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .clr_onehot   (clrOnehot),
    .pending      (pending),
    .any_eligible (anyEligible),
    .sel_id       (selId)
  );

  assign accept    = (state == IDLE) && global_en && anyEligible;
  assign clrOnehot = accept ? (NUM_SRC'(1) << selId) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      savedPc  <= '0;
      activeId <= '0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      savedPc  <= savedPcNxt;
      activeId <= activeIdNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    savedPcNxt  = savedPc;
    activeIdNxt = activeId;
    case (state)
      IDLE: begin
        if (accept) begin
          activeIdNxt = selId;
          if (decode_is_jmp) begin
            stateNxt = WAIT_JMP;
            cntNxt   = JMP_LAST;
          end else if (fetch_has_imm) begin
            // Return past the immediate word, which is allowed through first.
            stateNxt   = WAIT_IMM;
            savedPcNxt = next_pc + PC_WIDTH'(1);
          end else begin
            stateNxt   = BUBBLE;
            cntNxt     = BUB_LAST;
            savedPcNxt = next_pc;
          end
        end
      end
      WAIT_IMM: begin
        stateNxt = BUBBLE;
        cntNxt   = BUB_LAST;
      end
      WAIT_JMP: begin
        if (cnt == 3'd0) begin
          // Jump target has resolved onto next_pc by now; that is the return address.
          savedPcNxt = next_pc;
          stateNxt   = BUBBLE;
          cntNxt     = BUB_LAST;
        end else begin
          cntNxt = cnt - 3'd1;
        end
      end
      BUBBLE: begin
        if (cnt == 3'd0) stateNxt = PUSH1;
        else             cntNxt   = cnt - 3'd1;
      end
      PUSH1:    stateNxt = PUSH2;
      PUSH2:    stateNxt = REDIRECT;
      REDIRECT: stateNxt = IDLE;
      default:  stateNxt = IDLE;
    endcase
  end

  always_comb begin
    inject_active  = 1'b0;
    inject_instr   = '0;
    save_pc_valid  = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      WAIT_JMP, BUBBLE: begin
        inject_active = 1'b1;
        inject_instr  = INSTR_WIDTH'(BUBBLE_INSTR);
      end
      PUSH1: begin
        inject_active = 1'b1;
        inject_instr  = INSTR_WIDTH'(INT_OP1);
        save_pc_valid = 1'b1;
      end
      PUSH2: begin
        inject_active = 1'b1;
        inject_instr  = INSTR_WIDTH'(INT_OP2);
        save_pc_valid = 1'b1;
      end
      REDIRECT: begin
        inject_active  = 1'b1;
        inject_instr   = INSTR_WIDTH'(BUBBLE_INSTR);
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign ivtTarget   = PC_WIDTH'(IVT_BASE) + PC_WIDTH'(activeId) * PC_WIDTH'(IVT_STRIDE);
  assign save_pc     = save_pc_valid  ? savedPc   : '0;
  assign redirect_pc = redirect_valid ? ivtTarget : '0;
  assign busy        = (state != IDLE);
  assign active_id   = activeId;

endmodule

// File: tb/tb_multi_source_interrupt_controller.sv
// Scoreboard bench: stimulus predicts each service, a negedge monitor checks what the DUT emits.
module tb_multi_source_interrupt_controller;

  localparam int BUBC = 1;
  localparam int JW   = 1;
  localparam logic [15:0] OP_BUB = 16'h07F8;
  localparam logic [15:0] OP_1   = 16'hF480;
  localparam logic [15:0] OP_2   = 16'hF4C0;

  logic        clk = 0;
  logic        rst;
  logic [3:0]  irq, irq_mask;
  logic        global_en, fetch_has_imm, decode_is_jmp;
  logic [31:0] next_pc;
  logic        inject_active, save_pc_valid, redirect_valid, busy;
  logic [15:0] inject_instr;
  logic [31:0] save_pc, redirect_pc;
  logic [1:0]  active_id;
  logic [3:0]  pending;

  multi_source_interrupt_controller dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask), .global_en(global_en),
    .fetch_has_imm(fetch_has_imm), .decode_is_jmp(decode_is_jmp), .next_pc(next_pc),
    .inject_active(inject_active), .inject_instr(inject_instr),
    .save_pc_valid(save_pc_valid), .save_pc(save_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .active_id(active_id), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] savePc;
    logic [3:0]  pendAtRedir;
    int          len;
    int          noInj;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0, nFail = 0;
  int   busyCnt = 0, noInjCnt = 0, saveIdx = 0, redirSeen = 0;
  logic [3:0] expPending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes one scoreboard entry per redirect.
  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0; noInjCnt = 0; saveIdx = 0;
    end else begin
      if (busy) begin
        busyCnt++;
        if (!inject_active) noInjCnt++;
      end
      if (save_pc_valid) begin
        if (q.size() == 0) check("unexpected_save", 1, 0);
        else begin
          check("save_pc", save_pc, q[0].savePc);
          check("push_instr", inject_instr, (saveIdx == 0) ? OP_1 : OP_2);
          saveIdx++;
        end
      end
      if (redirect_valid) begin
        redirSeen++;
        if (q.size() == 0) check("unexpected_redirect", 1, 0);
        else begin
          check("redirect_pc", redirect_pc, 32'(q[0].id * 2));
          check("active_id", active_id, q[0].id);
          check("pending_at_redirect", pending, q[0].pendAtRedir);
          check("busy_len", busyCnt, q[0].len);
          check("imm_pass_cycles", noInjCnt, q[0].noInj);
          check("push_count", saveIdx, 2);
          check("redirect_instr", inject_instr, OP_BUB);
          void'(q.pop_front());
        end
        busyCnt = 0; noInjCnt = 0; saveIdx = 0;
      end
    end
  end

  task automatic waitBusy(input logic lvl, input string name);
    int n = 0;
    while (busy !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) check(name, busy, lvl);
  endtask

  task automatic waitPush(input logic [15:0] ins);
    int n = 0;
    while (!(save_pc_valid === 1'b1 && inject_instr === ins) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("wait_push_timeout", 0, 1);
  endtask

  function automatic int lowestBit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic doTxn();
    logic [3:0]  newR, mask, tot, elig, midB, pendAfter;
    logic [31:0] pcA, tgt, sp;
    int mode, id, len, noInj;
    newR = 4'($urandom);
    mask = 4'($urandom);
    tot  = expPending | newR;
    if (tot == 0) begin
      newR = 4'b0001 << $urandom_range(3);
      tot  = newR;
    end
    elig = tot & ~mask;
    if (elig == 0) begin
      mask[lowestBit(tot)] = 1'b0;
      elig = tot & ~mask;
    end
    id   = lowestBit(elig);
    mode = $urandom_range(2);
    pcA  = $urandom;
    if ($urandom_range(3) == 0) pcA = 32'hFFFF_FFFF;
    tgt  = $urandom;
    case (mode)
      1:       begin sp = pcA + 32'd1; len = 1 + BUBC + 3;  noInj = 1; end
      2:       begin sp = tgt;         len = JW + BUBC + 3; noInj = 0; end
      default: begin sp = pcA;         len = BUBC + 3;      noInj = 0; end
    endcase
    midB      = ($urandom_range(1) == 1) ? (4'b0001 << $urandom_range(3)) : 4'b0000;
    pendAfter = (tot & ~(4'b0001 << id)) | midB;

    @(negedge clk);
    irq = newR; irq_mask = mask;
    @(negedge clk);
    global_en = 1; fetch_has_imm = (mode == 1); decode_is_jmp = (mode == 2); next_pc = pcA;
    q.push_back('{id, sp, pendAfter, len, noInj});
    @(negedge clk);
    check("accept_busy", busy, 1);
    global_en = 0; irq = 0; fetch_has_imm = 0; decode_is_jmp = 0;
    next_pc = (mode == 2) ? tgt : $urandom;
    @(negedge clk);
    irq = midB;
    waitBusy(0, "service_timeout");
    expPending = pendAfter;
    @(negedge clk);
    irq = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; irq = 0; irq_mask = 0; global_en = 0;
    fetch_has_imm = 0; decode_is_jmp = 0; next_pc = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_inject", {inject_active, inject_instr}, 0);
    check("rst_valids", {save_pc_valid, redirect_valid}, 0);
    check("rst_pending", pending, 0);
    check("rst_active_id", active_id, 0);
    rst = 0;

    // Source 2 serviced; source 0 edges in during PUSH1 and is taken right after.
    @(negedge clk);
    irq = 4'b0100;
    @(negedge clk);
    global_en = 1; next_pc = 32'h40;
    q.push_back('{2, 32'h40, 4'b0001, BUBC + 3, 0});
    q.push_back('{0, 32'h40, 4'b0000, BUBC + 3, 0});
    waitPush(OP_1);
    irq = 4'b0101;
    while (redirect_valid !== 1'b1 && busy === 1'b1) @(negedge clk);
    @(negedge clk);
    check("idle_gap_after_redirect", busy, 0);
    @(negedge clk);
    check("back_to_back_accept", {busy, active_id}, {1'b1, 2'd0});
    waitBusy(0, "nested_timeout");
    global_en = 0; irq = 0;

    // Edge on source 3 lands on the same edge that accepts source 3.
    @(negedge clk); irq = 4'b1000;
    @(negedge clk); irq = 4'b0000;
    @(negedge clk); irq = 4'b1000; global_en = 1; next_pc = 32'h80;
    q.push_back('{3, 32'h80, 4'b1000, BUBC + 3, 0});
    @(negedge clk); global_en = 0; irq = 0;
    waitBusy(0, "setclr_timeout");
    expPending = 4'b1000;

    for (int t = 0; t < 40; t++) doTxn();
    check("queue_drained", q.size(), 0);

    // Asynchronous reset in the middle of PUSH2.
    @(negedge clk);
    irq = 4'b0100; irq_mask = 4'b1011;
    @(negedge clk);
    global_en = 1; next_pc = 32'h40;
    q.push_back('{2, 32'h40, 4'b0000, BUBC + 3, 0});
    waitPush(OP_2);
    #2 rst = 1; irq = 4'b0010;
    #1;
    check("midrst_inject", {inject_active, inject_instr}, 0);
    check("midrst_valids", {save_pc_valid, redirect_valid, busy}, 0);
    check("midrst_pending", pending, 0);
    q.delete();
    global_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0; redirSeen = 0;
    repeat (20) @(negedge clk);
    check("no_redirect_after_rst", redirSeen, 0);
    check("held_irq_edge_after_rst", {busy, pending}, {1'b0, 4'b0010});

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/multi_source_interrupt_controller.md
Name: multi_source_interrupt_controller

Overview:
- Parametrised successor to the single-line interrupt handler.
- Accepts NUM_SRC edge-triggered interrupt lines and latches them as pending. Applies a per-source mask and fixed priority (lowest index wins).
- Per interrupt, injects a fixed instruction sequence into the fetch/decode boundary: bubble(s), then the two-word PC-push pair, then redirects fetch to the source's IVT slot.
- Sits beside fetch; fetch muxes inject_instr over memory output while inject_active=1.

Parameters:
- NUM_SRC, 4, number of interrupt lines (1..16)
- PC_WIDTH, 32, program counter width
- INSTR_WIDTH, 16, instruction word width
- BUBBLE_CYCLES, 1, bubble cycles before the push pair (1..7)
- JMP_WAIT, 1, cycles waited for a decode-stage jump to resolve (1..7)
- IVT_BASE, 0, PC of IVT slot 0
- IVT_STRIDE, 2, PC distance between IVT slots

Ports:
- clk, in, 1, clock (rising edge)
- rst, in, 1, asynchronous reset, active-high
- irq, in, NUM_SRC, interrupt request lines
- irq_mask, in, NUM_SRC, 1 = source masked (stays pending, never selected)
- global_en, in, 1, 0 = no new acceptance
- fetch_has_imm, in, 1, instruction in fetch carries an immediate word
- decode_is_jmp, in, 1, jump in decode, target not yet resolved
- next_pc, in, PC_WIDTH, PC fetch would use next
- inject_active, out, 1, fetch must take inject_instr
- inject_instr, out, INSTR_WIDTH, injected instruction
- save_pc_valid, out, 1, save_pc is the return address
- save_pc, out, PC_WIDTH, return address for the push pair
- redirect_valid, out, 1, fetch loads redirect_pc next cycle
- redirect_pc, out, PC_WIDTH, IVT_BASE + active_id*IVT_STRIDE
- busy, out, 1, state != IDLE
- active_id, out, clog2(NUM_SRC) (min 1), source in service
- pending, out, NUM_SRC, pending register

Behaviour:
- Reset (async, any time, including mid-sequence):
  - state=IDLE; pending=0; irq_q=0; counter=0; saved PC=0; active_id=0.
  - All outputs 0; inject_instr=0.
  - A line held high through reset registers as one edge after release.
- Edge detect: rise = irq & ~irq_q. irq_q <= irq every cycle.
- Pending update: pending <= (pending & ~clr) | rise.
  - Set wins over same-cycle clear of the same bit.
  - A second edge while already pending is absorbed (no count).
- Acceptance happens only in IDLE, when global_en=1 and (pending & ~irq_mask) != 0.
  - The lowest set index is chosen; its bit clears (clr) and active_id is loaded.
  - Uses the registered pending only: an edge before clock edge E0 sets pending at E0 and is accepted at E1.
- Next state from acceptance, sampled at the accept edge (priority order):
  - decode_is_jmp=1: WAIT_JMP, counter=JMP_WAIT-1.
  - fetch_has_imm=1: WAIT_IMM; saved PC = next_pc+1.
  - otherwise: BUBBLE, counter=BUBBLE_CYCLES-1; saved PC = next_pc.
- States and Moore outputs (decoded from registered state only; no input-to-output path):
  - IDLE: inject_active=0.
  - WAIT_IMM: inject_active=0 (immediate word passes); 1 cycle; then BUBBLE.
  - WAIT_JMP: inject_active=1, instr=BUBBLE; counts down. At counter=0, saved PC = next_pc (resolved target); then BUBBLE.
  - BUBBLE: inject_active=1, instr=BUBBLE; counts to 0; then PUSH1.
  - PUSH1: inject INT_OP1; save_pc_valid=1; then PUSH2.
  - PUSH2: inject INT_OP2; save_pc_valid=1; then REDIRECT.
  - REDIRECT: inject BUBBLE; redirect_valid=1; then IDLE.
- Width rules:
  - PC arithmetic is modulo 2^PC_WIDTH (next_pc+1 wraps).
  - redirect_pc is computed at PC_WIDTH and truncated.
- Edges arriving while busy latch into pending. Serviced after return to IDLE, earliest acceptance at the edge after REDIRECT exits (no back-to-back overlap).
- Masking a pending source while busy has no effect on the current service.
- global_en=0 while busy does not abort the sequence.

Decomposition:
- Package int_ctrl_pkg holds:
  - state enum: IDLE, WAIT_IMM, WAIT_JMP, BUBBLE, PUSH1, PUSH2, REDIRECT
  - BUBBLE_INSTR = 16'h07F8
  - INT_OP1 = 16'hF480
  - INT_OP2 = 16'hF4C0
- Sub-module irq_pending_prio: edge detect, pending register, mask, and lowest-index priority encoder. Outputs: any_eligible, sel_id. Input: clr_onehot.

Test Plan:
- Normal: NUM_SRC=4, irq[2] rises, next_pc=0x40, no jmp/imm.
  - Pending[2] at E0; BUBBLE E1–E2; PUSH1/PUSH2 with save_pc=0x40.
  - REDIRECT with redirect_pc=4; busy for 4 cycles; pending=0.
- Immediate: fetch_has_imm=1, next_pc=0x10 at accept.
  - One WAIT_IMM cycle with inject_active=0; then bubble, push pair with save_pc=0x11.
- Jump: decode_is_jmp=1, JMP_WAIT=1, next_pc=0x200 at the WAIT_JMP edge.
  - Bubble injected; save_pc=0x200 in PUSH1/PUSH2.
- Priority/mask: irq[1] and irq[3] rise together, irq_mask[1]=1.
  - Source 3 serviced (redirect_pc=6); pending=0b0010 held.
  - Unmask later: source 1 serviced, redirect_pc=2.
- Nested/sim: irq[0] rises during PUSH1 of source 2.
  - Pending[0] set; accepted at the first edge after REDIRECT.
  - Same-cycle clear/set of one bit leaves it pending.
- Reset mid-PUSH2: rst pulse asynchronously.
  - All outputs 0 immediately; pending=0; no redirect issued afterward.
